ccu_ctrl: RTL and testbench
===========================

# ccu_ctrl

Central control unit of the TS3D accelerator: fetches per-layer configuration words from the host interface and distributes them to the global buffer (GB), pooling unit (POOL) and partial-sum buffer (GBPSUM). It then sequences the frame/block compute loop by pulsing the PE block array (PEB) and waiting for its completion. At layer end it hands off to POOL before loading the next layer.

## Interface
- CFG_W, 64: IFCFG_data width.
- CNT_W, 16: width of all GB count fields.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- ASICCCU_start  in  1  level; leaves IDLE when high.
- IFCFG_val / CFGIF_rdy  in / out  1  config-word handshake; IFCFG_data  in  CFG_W.
- CFGGB_val  out 1; GBCFG_rdy in 1; CFGGB_num_alloc_{wei,flgwei,flgact,act}, CFGGB_num_total_{flgwei,flgact,act}  out  CNT_W; CFGGB_num_loop_{wei,act}  out 8.
- CFGPOOL_val out 1; POOLCFG_rdy in 1; CFGPOOL_data out 16.
- CFGGBPSUM_val out 1; GBPSUMCFG_rdy in 1; CFGGBPSUM_num_frame, CFGGBPSUM_num_block out 8.
- CCUGB_reset_all, CCUGB_reset_patch, CCUGB_pullback_wei, CCUPOOL_reset, CCUPEB_next_block, CCUPEB_reset_act, CCUPEB_reset_wei  out 1  one-cycle pulses.
- CCUGB_frame, CCUGB_block  out 8  current loop indices.
- PEBCCU_fnh_block  in 1  block done pulse.
- CCUPOOL_En, CCUPOOL_ValFrm, CCUPOOL_ValDelta, CCUPOOL_layer_fnh  out 1; POOLCCU_clear_up  in 1.

## Operation
- Layer = 3 config words. W0: alloc_wei[15:0], alloc_flgwei[31:16], alloc_flgact[47:32], alloc_act[63:48]. W1: total_flgwei[15:0], total_flgact[31:16], total_act[47:32], loop_wei[55:48], loop_act[63:56]. W2: num_frame[7:0], num_block[15:8], pool_data[31:16], pool_en[32], last_layer[33]; rest reserved, ignored.
- States: IDLE → CFG → DISP → FRM → ISSUE → WAIT → (ISSUE | FRM | LFNH) → CFG or IDLE.
- IDLE: start=1 → CFG.
- CFG entry: pulse CCUGB_reset_all, CCUPOOL_reset, CCUPEB_reset_wei. CFGIF_rdy=1; latch a word per val&rdy into W0,W1,W2 order; after W2 → DISP.
- DISP: raise all three cfg vals together; each drops the cycle after its own rdy handshake; leave when all three done. Count outputs hold latched values until next layer.
- FRM: pulse CCUPEB_reset_act, CCUGB_reset_patch; block:=0 → ISSUE.
- ISSUE: pulse CCUPEB_next_block → WAIT.
- WAIT: on fnh_block: block+1<num_block → block++, ISSUE; else if frame+1<num_frame → pulse CCUGB_pullback_wei, frame++, FRM; else → LFNH.
- LFNH: CCUPOOL_layer_fnh=1 until POOLCCU_clear_up; then last_layer ? IDLE : CFG.
- CCUPOOL_En=pool_en during FRM/ISSUE/WAIT; ValFrm=(frame==0), ValDelta=(frame!=0), both gated by En.
- num_frame or num_block =0 treated as 1.

## Timing
- Reset: every output 0, state IDLE, indices 0.
- All outputs registered. CFG reached 1 cycle after start sampled high.
- Pulses exactly one cycle wide.
- fnh_block sampled only in WAIT; ignored elsewhere, including the ISSUE cycle.
- clear_up sampled only in LFNH; IFCFG_val ignored outside CFG.
- rdy arriving same cycle as val rise completes that handshake.
- rst_n low mid-layer: immediate return to IDLE, all outputs 0.

## Configuration
- CCU_ASSERT_EN: compiles simulation assertions: each cfg val held until rdy; no fnh_block outside WAIT; no X on inputs after reset. Without it: identical RTL, no checks.

## Structure
- Package ccu_pkg: state enum, CFG_W/CNT_W, word field offsets, packed layer-config struct.
- Sub-module ccu_cfg_rx: 3-word collector with handshake and layer-config register.

## Test plan
- Reset held 5 cycles → all outputs 0; release with start=1 → CFGIF_rdy=1 next cycle plus reset_all/reset_wei pulses.
- Load W0..W2 (alloc_wei=40959, total_flgact=10239, frames=2, blocks=3) → CFGGB_num_alloc_wei=40959, CFGGBPSUM_num_frame=2.
- GBCFG_rdy delayed 4 cycles, others immediate → CFGGB_val held 4 cycles, others drop after 1; DISP exit after GB.
- frames=2, blocks=3, fnh 2 cycles after each next_block → 6 next_block pulses, 1 pullback_wei, 2 reset_patch, ValDelta high only in frame 1.
- Spurious fnh_block during DISP → ignored; block index unchanged.
- last_layer=1, clear_up after 3 cycles → layer_fnh high 3 cycles, then IDLE; start held high → new CFG.

Source files
------------

// File: rtl/ccu_pkg.sv
// Shared types and constants for the TS3D central control unit.
// Optional simulation checks in ccu_ctrl are enabled with CCU_ASSERT_EN.
package ccu_pkg;

    localparam int unsigned CFG_W  = 64;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned POOL_W = 16;

    // Field offsets inside the three layer configuration words
    localparam int unsigned W0_ALLOC_WEI    = 0;
    localparam int unsigned W0_ALLOC_FLGWEI = 16;
    localparam int unsigned W0_ALLOC_FLGACT = 32;
    localparam int unsigned W0_ALLOC_ACT    = 48;
    localparam int unsigned W1_TOTAL_FLGWEI = 0;
    localparam int unsigned W1_TOTAL_FLGACT = 16;
    localparam int unsigned W1_TOTAL_ACT    = 32;
    localparam int unsigned W1_LOOP_WEI     = 48;
    localparam int unsigned W1_LOOP_ACT     = 56;
    localparam int unsigned W2_NUM_FRAME    = 0;
    localparam int unsigned W2_NUM_BLOCK    = 8;
    localparam int unsigned W2_POOL_DATA    = 16;
    localparam int unsigned W2_POOL_EN      = 32;
    localparam int unsigned W2_LAST_LAYER   = 33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_DISP,
        ST_FRM,
        ST_ISSUE,
        ST_WAIT,
        ST_LFNH
    } ccu_state_e;

    typedef struct packed {
        logic [CNT_W-1:0]  alloc_wei;
        logic [CNT_W-1:0]  alloc_flgwei;
        logic [CNT_W-1:0]  alloc_flgact;
        logic [CNT_W-1:0]  alloc_act;
        logic [CNT_W-1:0]  total_flgwei;
        logic [CNT_W-1:0]  total_flgact;
        logic [CNT_W-1:0]  total_act;
        logic [IDX_W-1:0]  loop_wei;
        logic [IDX_W-1:0]  loop_act;
        logic [IDX_W-1:0]  num_frame;
        logic [IDX_W-1:0]  num_block;
        logic [POOL_W-1:0] pool_data;
        logic              pool_en;
        logic              last_layer;
    } layer_cfg_t;

endpackage

// File: rtl/ccu_if.sv
// Bus bundle between the control unit and host/GB/POOL/GBPSUM/PEB.
// master = control unit side, slave = surrounding blocks.
interface ccu_if;
    import ccu_pkg::*;

    logic                ASICCCU_start;
    logic                IFCFG_val;
    logic                CFGIF_rdy;
    logic [CFG_W-1:0]    IFCFG_data;

    logic                CFGGB_val;
    logic                GBCFG_rdy;
    logic [CNT_W-1:0]    CFGGB_num_alloc_wei;
    logic [CNT_W-1:0]    CFGGB_num_alloc_flgwei;
    logic [CNT_W-1:0]    CFGGB_num_alloc_flgact;
    logic [CNT_W-1:0]    CFGGB_num_alloc_act;
    logic [CNT_W-1:0]    CFGGB_num_total_flgwei;
    logic [CNT_W-1:0]    CFGGB_num_total_flgact;
    logic [CNT_W-1:0]    CFGGB_num_total_act;
    logic [IDX_W-1:0]    CFGGB_num_loop_wei;
    logic [IDX_W-1:0]    CFGGB_num_loop_act;

    logic                CFGPOOL_val;
    logic                POOLCFG_rdy;
    logic [POOL_W-1:0]   CFGPOOL_data;

    logic                CFGGBPSUM_val;
    logic                GBPSUMCFG_rdy;
    logic [IDX_W-1:0]    CFGGBPSUM_num_frame;
    logic [IDX_W-1:0]    CFGGBPSUM_num_block;

    logic                CCUGB_reset_all;
    logic                CCUGB_reset_patch;
    logic                CCUGB_pullback_wei;
    logic                CCUPOOL_reset;
    logic                CCUPEB_next_block;
    logic                CCUPEB_reset_act;
    logic                CCUPEB_reset_wei;
    logic [IDX_W-1:0]    CCUGB_frame;
    logic [IDX_W-1:0]    CCUGB_block;
    logic                PEBCCU_fnh_block;

    logic                CCUPOOL_En;
    logic                CCUPOOL_ValFrm;
    logic                CCUPOOL_ValDelta;
    logic                CCUPOOL_layer_fnh;
    logic                POOLCCU_clear_up;

    modport master (
        input  ASICCCU_start, IFCFG_val, IFCFG_data, GBCFG_rdy, POOLCFG_rdy,
               GBPSUMCFG_rdy, PEBCCU_fnh_block, POOLCCU_clear_up,
        output CFGIF_rdy, CFGGB_val, CFGGB_num_alloc_wei, CFGGB_num_alloc_flgwei,
               CFGGB_num_alloc_flgact, CFGGB_num_alloc_act, CFGGB_num_total_flgwei,
               CFGGB_num_total_flgact, CFGGB_num_total_act, CFGGB_num_loop_wei,
               CFGGB_num_loop_act, CFGPOOL_val, CFGPOOL_data, CFGGBPSUM_val,
               CFGGBPSUM_num_frame, CFGGBPSUM_num_block, CCUGB_reset_all,
               CCUGB_reset_patch, CCUGB_pullback_wei, CCUPOOL_reset, CCUPEB_next_block,
               CCUPEB_reset_act, CCUPEB_reset_wei, CCUGB_frame, CCUGB_block,
               CCUPOOL_En, CCUPOOL_ValFrm, CCUPOOL_ValDelta, CCUPOOL_layer_fnh
    );

    modport slave (
        output ASICCCU_start, IFCFG_val, IFCFG_data, GBCFG_rdy, POOLCFG_rdy,
               GBPSUMCFG_rdy, PEBCCU_fnh_block, POOLCCU_clear_up,
        input  CFGIF_rdy, CFGGB_val, CFGGB_num_alloc_wei, CFGGB_num_alloc_flgwei,
               CFGGB_num_alloc_flgact, CFGGB_num_alloc_act, CFGGB_num_total_flgwei,
               CFGGB_num_total_flgact, CFGGB_num_total_act, CFGGB_num_loop_wei,
               CFGGB_num_loop_act, CFGPOOL_val, CFGPOOL_data, CFGGBPSUM_val,
               CFGGBPSUM_num_frame, CFGGBPSUM_num_block, CCUGB_reset_all,
               CCUGB_reset_patch, CCUGB_pullback_wei, CCUPOOL_reset, CCUPEB_next_block,
               CCUPEB_reset_act, CCUPEB_reset_wei, CCUGB_frame, CCUGB_block,
               CCUPOOL_En, CCUPOOL_ValFrm, CCUPOOL_ValDelta, CCUPOOL_layer_fnh
    );

endinterface

// File: rtl/ccu_cfg_rx.sv
// Collects the three configuration words of a layer over a val/rdy
// handshake and holds them in the layer-config register.
module ccu_cfg_rx
    import ccu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open_c,
    input  logic             val,
    input  logic [CFG_W-1:0] data,
    output logic             rdy,
    output logic             done_c,
    output layer_cfg_t       cfg
);

    logic [1:0] word;
    logic       take_c;

    assign take_c = val & rdy;
    assign done_c = take_c & (word == 2'd2);

    // rdy follows the controller's next state so it is high on the first CFG cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy  <= 1'b0;
            word <= 2'd0;
            cfg  <= '0;
        end else begin
            rdy <= open_c;
            if (!rdy) begin
                word <= 2'd0;
            end else if (take_c) begin
                word <= (word == 2'd2) ? 2'd0 : word + 2'd1;
            end
            if (take_c) begin
                case (word)
                    2'd0: begin
                        cfg.alloc_wei    <= data[W0_ALLOC_WEI    +: CNT_W];
                        cfg.alloc_flgwei <= data[W0_ALLOC_FLGWEI +: CNT_W];
                        cfg.alloc_flgact <= data[W0_ALLOC_FLGACT +: CNT_W];
                        cfg.alloc_act    <= data[W0_ALLOC_ACT    +: CNT_W];
                    end
                    2'd1: begin
                        cfg.total_flgwei <= data[W1_TOTAL_FLGWEI +: CNT_W];
                        cfg.total_flgact <= data[W1_TOTAL_FLGACT +: CNT_W];
                        cfg.total_act    <= data[W1_TOTAL_ACT    +: CNT_W];
                        cfg.loop_wei     <= data[W1_LOOP_WEI     +: IDX_W];
                        cfg.loop_act     <= data[W1_LOOP_ACT     +: IDX_W];
                    end
                    default: begin
                        cfg.num_frame  <= data[W2_NUM_FRAME +: IDX_W];
                        cfg.num_block  <= data[W2_NUM_BLOCK +: IDX_W];
                        cfg.pool_data  <= data[W2_POOL_DATA +: POOL_W];
                        cfg.pool_en    <= data[W2_POOL_EN];
                        cfg.last_layer <= data[W2_LAST_LAYER];
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ccu_ctrl.sv
// TS3D central control unit: layer config fetch/dispatch and frame/block sequencing.
// Define CCU_ASSERT_EN to compile the simulation protocol checks.
module ccu_ctrl
    import ccu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    ccu_if.master    bus
);

    ccu_state_e       state, state_n;
    layer_cfg_t       cfg;
    logic             cfg_done_c;
    logic [IDX_W-1:0] frame, frame_n, block, block_n;
    logic [IDX_W-1:0] nf_eff, nb_eff;
    logic             gb_val_n, pool_val_n, psum_val_n, pullback_n, en_n;

    ccu_cfg_rx u_cfg_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .open_c (state_n == ST_CFG),
        .val    (bus.IFCFG_val),
        .data   (bus.IFCFG_data),
        .rdy    (bus.CFGIF_rdy),
        .done_c (cfg_done_c),
        .cfg    (cfg)
    );

    // A zero loop count still runs one iteration
    assign nf_eff = (cfg.num_frame == '0) ? IDX_W'(1) : cfg.num_frame;
    assign nb_eff = (cfg.num_block == '0) ? IDX_W'(1) : cfg.num_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        frame_n    = frame;
        block_n    = block;
        gb_val_n   = bus.CFGGB_val     & ~bus.GBCFG_rdy;
        pool_val_n = bus.CFGPOOL_val   & ~bus.POOLCFG_rdy;
        psum_val_n = bus.CFGGBPSUM_val & ~bus.GBPSUMCFG_rdy;
        pullback_n = 1'b0;
        case (state)
            ST_IDLE: if (bus.ASICCCU_start) state_n = ST_CFG;
            ST_CFG: begin
                frame_n = '0;
                if (cfg_done_c) begin
                    state_n    = ST_DISP;
                    gb_val_n   = 1'b1;
                    pool_val_n = 1'b1;
                    psum_val_n = 1'b1;
                end
            end
            ST_DISP: if (!gb_val_n && !pool_val_n && !psum_val_n) state_n = ST_FRM;
            ST_FRM: begin
                block_n = '0;
                state_n = ST_ISSUE;
            end
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT: begin
                if (bus.PEBCCU_fnh_block) begin
                    if ((9'(block) + 9'd1) < 9'(nb_eff)) begin
                        block_n = block + IDX_W'(1);
                        state_n = ST_ISSUE;
                    end else if ((9'(frame) + 9'd1) < 9'(nf_eff)) begin
                        pullback_n = 1'b1;
                        frame_n    = frame + IDX_W'(1);
                        state_n    = ST_FRM;
                    end else begin
                        state_n = ST_LFNH;
                    end
                end
            end
            ST_LFNH: if (bus.POOLCCU_clear_up) state_n = cfg.last_layer ? ST_IDLE : ST_CFG;
            default: state_n = ST_IDLE;
        endcase
        en_n = cfg.pool_en & ((state_n == ST_FRM) || (state_n == ST_ISSUE) || (state_n == ST_WAIT));
    end

    // Outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame                  <= '0;
            block                  <= '0;
            bus.CFGGB_val          <= 1'b0;
            bus.CFGPOOL_val        <= 1'b0;
            bus.CFGGBPSUM_val      <= 1'b0;
            bus.CCUGB_reset_all    <= 1'b0;
            bus.CCUPOOL_reset      <= 1'b0;
            bus.CCUPEB_reset_wei   <= 1'b0;
            bus.CCUGB_reset_patch  <= 1'b0;
            bus.CCUPEB_reset_act   <= 1'b0;
            bus.CCUPEB_next_block  <= 1'b0;
            bus.CCUGB_pullback_wei <= 1'b0;
            bus.CCUPOOL_layer_fnh  <= 1'b0;
            bus.CCUPOOL_En         <= 1'b0;
            bus.CCUPOOL_ValFrm     <= 1'b0;
            bus.CCUPOOL_ValDelta   <= 1'b0;
        end else begin
            frame                  <= frame_n;
            block                  <= block_n;
            bus.CFGGB_val          <= gb_val_n;
            bus.CFGPOOL_val        <= pool_val_n;
            bus.CFGGBPSUM_val      <= psum_val_n;
            bus.CCUGB_reset_all    <= (state_n == ST_CFG) && (state != ST_CFG);
            bus.CCUPOOL_reset      <= (state_n == ST_CFG) && (state != ST_CFG);
            bus.CCUPEB_reset_wei   <= (state_n == ST_CFG) && (state != ST_CFG);
            bus.CCUGB_reset_patch  <= (state_n == ST_FRM);
            bus.CCUPEB_reset_act   <= (state_n == ST_FRM);
            bus.CCUPEB_next_block  <= (state_n == ST_ISSUE);
            bus.CCUGB_pullback_wei <= pullback_n;
            bus.CCUPOOL_layer_fnh  <= (state_n == ST_LFNH);
            bus.CCUPOOL_En         <= en_n;
            bus.CCUPOOL_ValFrm     <= en_n & (frame_n == '0);
            bus.CCUPOOL_ValDelta   <= en_n & (frame_n != '0);
        end
    end

    assign bus.CCUGB_frame            = frame;
    assign bus.CCUGB_block            = block;
    assign bus.CFGGB_num_alloc_wei    = cfg.alloc_wei;
    assign bus.CFGGB_num_alloc_flgwei = cfg.alloc_flgwei;
    assign bus.CFGGB_num_alloc_flgact = cfg.alloc_flgact;
    assign bus.CFGGB_num_alloc_act    = cfg.alloc_act;
    assign bus.CFGGB_num_total_flgwei = cfg.total_flgwei;
    assign bus.CFGGB_num_total_flgact = cfg.total_flgact;
    assign bus.CFGGB_num_total_act    = cfg.total_act;
    assign bus.CFGGB_num_loop_wei     = cfg.loop_wei;
    assign bus.CFGGB_num_loop_act     = cfg.loop_act;
    assign bus.CFGPOOL_data           = cfg.pool_data;
    assign bus.CFGGBPSUM_num_frame    = cfg.num_frame;
    assign bus.CFGGBPSUM_num_block    = cfg.num_block;

`ifdef CCU_ASSERT_EN
    a_gb_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.CFGGB_val && !bus.GBCFG_rdy) |=> bus.CFGGB_val);
    a_pool_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.CFGPOOL_val && !bus.POOLCFG_rdy) |=> bus.CFGPOOL_val);
    a_psum_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.CFGGBPSUM_val && !bus.GBPSUMCFG_rdy) |=> bus.CFGGBPSUM_val);
    a_fnh_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        bus.PEBCCU_fnh_block |-> (state == ST_WAIT));
    a_no_x_in: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({bus.ASICCCU_start, bus.IFCFG_val, bus.IFCFG_data, bus.GBCFG_rdy,
                     bus.POOLCFG_rdy, bus.GBPSUMCFG_rdy, bus.PEBCCU_fnh_block,
                     bus.POOLCCU_clear_up}));
`endif

endmodule

// File: tb/tb_ccu_ctrl.sv
// Directed self-checking bench for ccu_ctrl: reset, config load, dispatch
// handshakes, frame/block loop, layer finish and mid-layer reset.
module tb_ccu_ctrl;
    import ccu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [255:0] outs_all;

    ccu_if bus ();

    ccu_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign outs_all = 256'({bus.CFGIF_rdy, bus.CFGGB_val, bus.CFGGB_num_alloc_wei,
        bus.CFGGB_num_alloc_flgwei, bus.CFGGB_num_alloc_flgact, bus.CFGGB_num_alloc_act,
        bus.CFGGB_num_total_flgwei, bus.CFGGB_num_total_flgact, bus.CFGGB_num_total_act,
        bus.CFGGB_num_loop_wei, bus.CFGGB_num_loop_act, bus.CFGPOOL_val, bus.CFGPOOL_data,
        bus.CFGGBPSUM_val, bus.CFGGBPSUM_num_frame, bus.CFGGBPSUM_num_block,
        bus.CCUGB_reset_all, bus.CCUGB_reset_patch, bus.CCUGB_pullback_wei, bus.CCUPOOL_reset,
        bus.CCUPEB_next_block, bus.CCUPEB_reset_act, bus.CCUPEB_reset_wei, bus.CCUGB_frame,
        bus.CCUGB_block, bus.CCUPOOL_En, bus.CCUPOOL_ValFrm, bus.CCUPOOL_ValDelta,
        bus.CCUPOOL_layer_fnh});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [CFG_W-1:0] w);
        bus.IFCFG_val  = 1'b1;
        bus.IFCFG_data = w;
        step();
        bus.IFCFG_val  = 1'b0;
    endtask

    initial begin
        int  nb_cnt, pb_cnt, rp_cnt, vd_bad, vd_seen, vf_seen, cd, lf_cnt;
        bit  done;
        rst_n                = 1'b0;
        bus.ASICCCU_start    = 1'b0;
        bus.IFCFG_val        = 1'b0;
        bus.IFCFG_data       = '0;
        bus.GBCFG_rdy        = 1'b0;
        bus.POOLCFG_rdy      = 1'b0;
        bus.GBPSUMCFG_rdy    = 1'b0;
        bus.PEBCCU_fnh_block = 1'b0;
        bus.POOLCCU_clear_up = 1'b0;

        repeat (5) step();
        check("reset_outs_zero", 64'($countones(outs_all)), 64'd0);
        check("reset_rdy", 64'(bus.CFGIF_rdy), 64'd0);

        rst_n             = 1'b1;
        bus.ASICCCU_start = 1'b1;
        step();
        bus.ASICCCU_start = 1'b0;
        check("cfg_rdy", 64'(bus.CFGIF_rdy), 64'd1);
        check("cfg_reset_all", 64'(bus.CCUGB_reset_all), 64'd1);
        check("cfg_reset_wei", 64'(bus.CCUPEB_reset_wei), 64'd1);
        check("cfg_pool_reset", 64'(bus.CCUPOOL_reset), 64'd1);

        // Layer 1: 2 frames x 3 blocks, pooling on, last layer, reserved W2 bits set
        send_word(64'h0033_0022_0011_9FFF);
        check("reset_all_1cyc", 64'(bus.CCUGB_reset_all), 64'd0);
        send_word(64'h0504_0303_27FF_0101);
        send_word(64'hFFFF_FFF3_BEEF_0302);
        check("alloc_wei", 64'(bus.CFGGB_num_alloc_wei), 64'd40959);
        check("total_flgact", 64'(bus.CFGGB_num_total_flgact), 64'd10239);
        check("loop_act", 64'(bus.CFGGB_num_loop_act), 64'd5);
        check("psum_frame", 64'(bus.CFGGBPSUM_num_frame), 64'd2);
        check("psum_block", 64'(bus.CFGGBPSUM_num_block), 64'd3);
        check("pool_data", 64'(bus.CFGPOOL_data), 64'hBEEF);
        check("disp_vals_rise", 64'({bus.CFGGB_val, bus.CFGPOOL_val, bus.CFGGBPSUM_val}), 64'b111);
        check("disp_rdy_low", 64'(bus.CFGIF_rdy), 64'd0);

        // Dispatch: GB ready late, others immediate, spurious fnh_block meanwhile
        bus.POOLCFG_rdy      = 1'b1;
        bus.GBPSUMCFG_rdy    = 1'b1;
        bus.PEBCCU_fnh_block = 1'b1;
        step();
        check("disp_c2_vals", 64'({bus.CFGGB_val, bus.CFGPOOL_val, bus.CFGGBPSUM_val}), 64'b100);
        step();
        check("disp_c3_gb", 64'(bus.CFGGB_val), 64'd1);
        step();
        check("disp_c4_gb", 64'(bus.CFGGB_val), 64'd1);
        check("spur_fnh_block", 64'(bus.CCUGB_block), 64'd0);
        check("spur_fnh_nb", 64'(bus.CCUPEB_next_block), 64'd0);
        bus.PEBCCU_fnh_block = 1'b0;
        bus.GBCFG_rdy        = 1'b1;
        step();
        bus.GBCFG_rdy        = 1'b0;
        check("frm_gb_val", 64'(bus.CFGGB_val), 64'd0);
        check("frm_reset_act", 64'(bus.CCUPEB_reset_act), 64'd1);
        check("frm_pool_en", 64'({bus.CCUPOOL_En, bus.CCUPOOL_ValFrm, bus.CCUPOOL_ValDelta}), 64'b110);

        // Compute loop: fnh_block two cycles after each next_block
        nb_cnt = 0; pb_cnt = 0; rp_cnt = 0; vd_bad = 0; vd_seen = 0; vf_seen = 0; cd = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.CCUPOOL_layer_fnh) begin
                done = 1'b1;
            end else begin
                if (bus.CCUPEB_next_block)  nb_cnt++;
                if (bus.CCUGB_pullback_wei) pb_cnt++;
                if (bus.CCUGB_reset_patch)  rp_cnt++;
                if (bus.CCUPOOL_ValDelta && bus.CCUGB_frame == 8'd0) vd_bad++;
                if (bus.CCUPOOL_ValDelta && bus.CCUGB_frame == 8'd1) vd_seen++;
                if (bus.CCUPOOL_ValFrm && bus.CCUGB_frame == 8'd0)   vf_seen++;
                bus.PEBCCU_fnh_block = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) bus.PEBCCU_fnh_block = 1'b1;
                end
                if (bus.CCUPEB_next_block) cd = 2;
                step();
            end
        end
        bus.PEBCCU_fnh_block = 1'b0;
        check("loop_reached_lfnh", 64'(done), 64'd1);
        check("next_block_cnt", 64'(nb_cnt), 64'd6);
        check("pullback_cnt", 64'(pb_cnt), 64'd1);
        check("reset_patch_cnt", 64'(rp_cnt), 64'd2);
        check("valdelta_frame0", 64'(vd_bad), 64'd0);
        check("valdelta_frame1", 64'(vd_seen), 64'd10);
        check("valfrm_frame0", 64'(vf_seen), 64'd10);

        // Layer finish: clear_up on third cycle, start held high for the next pass
        lf_cnt = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!bus.CCUPOOL_layer_fnh) begin
                done = 1'b1;
            end else begin
                lf_cnt++;
                bus.POOLCCU_clear_up = (lf_cnt == 3);
                bus.ASICCCU_start    = (lf_cnt == 3);
                step();
            end
        end
        bus.POOLCCU_clear_up = 1'b0;
        check("layer_fnh_cycles", 64'(lf_cnt), 64'd3);
        check("idle_after_last", 64'(bus.CFGIF_rdy), 64'd0);
        step();
        bus.ASICCCU_start = 1'b0;
        check("restart_rdy", 64'(bus.CFGIF_rdy), 64'd1);
        check("restart_reset_all", 64'(bus.CCUGB_reset_all), 64'd1);

        // Layer 2: zero frame/block counts run once, pooling off, not last
        bus.GBCFG_rdy = 1'b1;
        send_word(64'h0);
        send_word(64'h0);
        send_word(64'h0);
        check("l2_num_frame", 64'(bus.CFGGBPSUM_num_frame), 64'd0);
        step();
        check("l2_frm_patch", 64'(bus.CCUGB_reset_patch), 64'd1);
        check("l2_pool_en_off", 64'(bus.CCUPOOL_En), 64'd0);
        step();
        check("l2_issue", 64'(bus.CCUPEB_next_block), 64'd1);
        step();
        check("l2_nb_1cyc", 64'(bus.CCUPEB_next_block), 64'd0);
        bus.PEBCCU_fnh_block = 1'b1;
        step();
        bus.PEBCCU_fnh_block = 1'b0;
        check("l2_lfnh", 64'(bus.CCUPOOL_layer_fnh), 64'd1);
        check("l2_pullback_none", 64'(bus.CCUGB_pullback_wei), 64'd0);

        // Asynchronous reset in the middle of a layer
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outs_zero", 64'($countones(outs_all)), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("midreset_idle", 64'(bus.CFGIF_rdy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
